// File: rtl/riscv_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_if
// Description : Core request/response and picorv32-style memory bus bundle
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_lsu_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_cause;

    logic              mem_valid;
    logic              mem_instr;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wstrb;
    logic [XLEN-1:0]   mem_rdata;

    // LSU side: accepts core requests, masters the memory bus
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );

    // Environment side: core issuing requests plus the memory responding
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : RV32/RV64 load/store unit: lane decode, store alignment,
//               load extension, misaligned/illegal trapping. Optional bus
//               timeout enabled by defining RISCV_LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    riscv_lsu_if.slave  bus
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]      r_state;
    logic            r_mem_valid;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [NB-1:0]   r_mem_wstrb;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic [1:0]      r_resp_cause;
    logic [XLEN-1:0] r_resp_rdata;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [OFS-1:0]  r_off;

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Request decode
    logic [3:0]      w_bytes;
    logic [OFS-1:0]  w_off;
    logic [OFS-1:0]  w_align;
    logic            w_legal;
    logic            w_misaligned;
    logic [8:0]      w_mask_full;
    logic [NB-1:0]   w_strb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_addr;

    assign w_bytes      = 4'd1 << bus.req_funct3[1:0];
    assign w_off        = bus.req_addr[OFS-1:0];
    assign w_align      = OFS'(w_bytes - 4'd1);
    assign w_misaligned = (w_off & w_align) != '0;
    assign w_mask_full  = (9'd1 << w_bytes) - 9'd1;
    assign w_strb       = w_mask_full[NB-1:0] << w_off;
    assign w_wdata      = bus.req_wdata << {w_off, 3'b000};
    assign w_addr       = {bus.req_addr[XLEN-1:OFS], {OFS{1'b0}}};

    always_comb begin
        w_legal = 1'b0;
        if (bus.req_store) begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                3'b011:                 w_legal = (XLEN == 64);
                default:                w_legal = 1'b0;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = (XLEN == 64);
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    // Load extraction: shift the addressed bytes to the top, then shift back
    // logically (zero-extend) or arithmetically (sign-extend).
    logic [XLEN-1:0]        w_rsh;
    logic [6:0]             w_bits;
    logic [6:0]             w_shamt;
    logic [XLEN-1:0]        w_trunc;
    logic signed [XLEN-1:0] w_trunc_s;
    logic [XLEN-1:0]        w_zext;
    logic [XLEN-1:0]        w_sext;
    logic [XLEN-1:0]        w_load;

    assign w_rsh     = bus.mem_rdata >> {r_off, 3'b000};
    assign w_bits    = 7'd8 << r_funct3[1:0];
    assign w_shamt   = 7'(XLEN) - w_bits;
    assign w_trunc   = w_rsh << w_shamt;
    assign w_trunc_s = w_trunc;
    assign w_zext    = w_trunc >> w_shamt;
    assign w_sext    = w_trunc_s >>> w_shamt;
    assign w_load    = r_funct3[2] ? w_zext : w_sext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 2'b00;
            r_resp_rdata <= '0;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= '0;
`ifdef RISCV_LSU_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 2'b00;
            r_resp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        // Illegal funct3 takes priority over alignment
                        if (!w_legal) begin
                            r_state      <= S_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= 2'b10;
                        end else if (w_misaligned) begin
                            r_state      <= S_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= 2'b01;
                        end else begin
                            r_state     <= S_BUS;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= bus.req_store ? w_strb : '0;
                            r_store     <= bus.req_store;
                            r_funct3    <= bus.req_funct3;
                            r_off       <= w_off;
`ifdef RISCV_LSU_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                S_BUS: begin
                    if (bus.mem_ready) begin
                        r_state      <= S_RESP;
                        r_mem_valid  <= 1'b0;
                        r_mem_wstrb  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_store ? '0 : w_load;
                    end
`ifdef RISCV_LSU_TIMEOUT_EN
                    else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_state      <= S_RESP;
                        r_mem_valid  <= 1'b0;
                        r_mem_wstrb  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= 2'b11;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_ERR, S_RESP: r_state <= S_IDLE;
                default:       r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_cause = r_resp_cause;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_instr  = 1'b0;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wstrb  = r_mem_wstrb;
endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Directed plus randomized self-checking bench for riscv_lsu
//               (XLEN=32, TIMEOUT=4), with a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;
    localparam int XLEN = 32;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    riscv_lsu_if #(.XLEN(XLEN)) bus ();

    riscv_lsu #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: works byte by byte from the access rules
    function automatic void model(
        input  bit          store,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        output bit          err,
        output logic [1:0]  cause,
        output logic [31:0] maddr,
        output logic [31:0] mwdata,
        output logic [31:0] res,
        output logic [3:0]  strb
    );
        int          size;
        int          off;
        bit          legal;
        logic [31:0] v;
        size   = 1 << f3[1:0];
        off    = int'(addr % 4);
        legal  = store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = 1'b0;
        cause  = 2'b00;
        maddr  = addr - 32'(off);
        mwdata = wdata << (8 * off);
        strb   = 4'b0000;
        res    = 32'h0;
        if (!legal) begin
            err   = 1'b1;
            cause = 2'b10;
        end else if ((addr % size) != 0) begin
            err   = 1'b1;
            cause = 2'b01;
        end else if (store) begin
            for (int b = 0; b < 4; b++) strb[b] = (b >= off) && (b < off + size);
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
            if (!f3[2] && v[8*size-1])
                for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
            res = v;
        end
    endfunction

    task automatic access(
        input  bit          store,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        input  int          waits,
        output logic [31:0] got,
        output logic [1:0]  got_cause,
        output logic [3:0]  got_strb,
        output logic [31:0] got_wdata
    );
        bit          e_err;
        logic [1:0]  e_cause;
        logic [31:0] e_addr, e_wdata, e_res;
        logic [3:0]  e_strb;
        int          guard;
        model(store, f3, addr, wdata, rdata, e_err, e_cause, e_addr, e_wdata, e_res, e_strb);
        got_strb  = 4'h0;
        got_wdata = 32'h0;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("req_ready_before", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        step();
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        chk("busy_ready", bus.req_ready, 1'b0);
        if (e_err) begin
            chk("err_resp_valid", bus.resp_valid, 1'b1);
            chk("err_flag", bus.resp_err, 1'b1);
            chk("err_cause", bus.resp_cause, e_cause);
            chk("err_rdata", bus.resp_rdata, 32'h0);
            chk("err_no_bus", bus.mem_valid, 1'b0);
        end else begin
            chk("mem_valid", bus.mem_valid, 1'b1);
            chk("mem_instr", bus.mem_instr, 1'b0);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wstrb", bus.mem_wstrb, e_strb);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("no_early_resp", bus.resp_valid, 1'b0);
            got_strb  = bus.mem_wstrb;
            got_wdata = bus.mem_wdata;
            for (int i = 0; i < waits; i++) begin
                step();
                chk("hold_valid", bus.mem_valid, 1'b1);
                chk("hold_addr", bus.mem_addr, e_addr);
                chk("hold_resp", bus.resp_valid, 1'b0);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rdata;
            step();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            chk("resp_valid", bus.resp_valid, 1'b1);
            chk("resp_err", bus.resp_err, 1'b0);
            chk("resp_cause", bus.resp_cause, 2'b00);
            chk("resp_rdata", bus.resp_rdata, e_res);
            chk("mem_valid_drop", bus.mem_valid, 1'b0);
        end
        got       = bus.resp_rdata;
        got_cause = bus.resp_cause;
        step();
        chk("resp_pulse", bus.resp_valid, 1'b0);
        chk("resp_rdata_idle", bus.resp_rdata, 32'h0);
        chk("ready_again", bus.req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] got, wd, a, r;
        logic [1:0]  cs;
        logic [3:0]  sb;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (2) step();
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_cause", bus.resp_cause, 2'b00);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        chk("rst_wstrb", bus.mem_wstrb, 4'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        #3 reset = 1'b0;
        step();

        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, got, cs, sb, wd);
        chk("lw_value", got, 32'hDEADBEEF);
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, got, cs, sb, wd);
        chk("lb_value", got, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, got, cs, sb, wd);
        chk("lbu_value", got, 32'h00000080);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, got, cs, sb, wd);
        chk("lhu_value", got, 32'h00008011);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, got, cs, sb, wd);
        chk("lh_value", got, 32'hFFFF8011);
        access(1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 1, got, cs, sb, wd);
        chk("sb_strb", sb, 4'b0010);
        chk("sb_lane", wd[15:8], 8'hAB);
        chk("sb_rdata", got, 32'h0);
        access(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, got, cs, sb, wd);
        chk("sh_strb", sb, 4'b1100);
        chk("sh_lane", wd[31:16], 16'h1234);
        access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, got, cs, sb, wd);
        chk("lw_misaligned", cs, 2'b01);
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, got, cs, sb, wd);
        chk("ld_illegal", cs, 2'b10);
        access(1'b1, 3'b101, 32'h101, 32'h0, 32'h0, 0, got, cs, sb, wd);
        chk("store_illegal_first", cs, 2'b10);

        // Stray mem_ready while idle must not produce a response
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("stray_ready_resp", bus.resp_valid, 1'b0);
        chk("stray_ready_idle", bus.req_ready, 1'b1);

        // Stalled bus: timeout build errors out, default build waits
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        step();
        bus.req_valid = 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_wait_valid", bus.mem_valid, 1'b1);
            chk("tmo_wait_resp", bus.resp_valid, 1'b0);
            step();
        end
        chk("tmo_resp_valid", bus.resp_valid, 1'b1);
        chk("tmo_err", bus.resp_err, 1'b1);
        chk("tmo_cause", bus.resp_cause, 2'b11);
        chk("tmo_mem_drop", bus.mem_valid, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            chk("stall_valid", bus.mem_valid, 1'b1);
            chk("stall_resp", bus.resp_valid, 1'b0);
            step();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000007F;
        step();
        bus.mem_ready = 1'b0;
        chk("stall_resp_valid", bus.resp_valid, 1'b1);
        chk("stall_err", bus.resp_err, 1'b0);
        chk("stall_rdata", bus.resp_rdata, 32'h0000007F);
`endif
        step();
        chk("post_stall_ready", bus.req_ready, 1'b1);

        // Reset in the middle of a bus cycle
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h301;
        step();
        bus.req_valid = 1'b0;
        chk("pre_abort_valid", bus.mem_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort_async_valid", bus.mem_valid, 1'b0);
        chk("abort_resp", bus.resp_valid, 1'b0);
        #2 reset = 1'b0;
        step();
        chk("post_abort_resp", bus.resp_valid, 1'b0);
        chk("post_abort_valid", bus.mem_valid, 1'b0);
        chk("post_abort_ready", bus.req_ready, 1'b1);

        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = $urandom;
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, r,
                   $urandom_range(0, TMO - 1), got, cs, sb, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
